// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the slave-mode I2S receiver: slot polarity and lock states.
package i2s_rx_pkg;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    LK_UNLOCKED = 2'd0,
    LK_ALIGNING = 2'd1,
    LK_LOCKED   = 2'd2
  } lock_e;

endpackage

// File: rtl/i2s_rx_sync_ff.sv
// Multi-stage synchronizer for one asynchronous input bit.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode Philips I2S receiver: oversamples sclk/lrclk/sdata, deframes MSB-first
// slots and presents coherent left/right pairs with a strobe once framing is locked.
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_chan,
  output logic [WIDTH-1:0] right_chan,
  output logic             sample_valid,
  output logic             locked,
  output logic             short_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  logic sclk_s, lr_s, sd_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d_i(sclk),  .q_o(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lr   (.clk(clk), .reset_n(reset_n), .d_i(lrclk), .q_o(lr_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd   (.clk(clk), .reset_n(reset_n), .d_i(sdata), .q_o(sd_s));

  logic             sclk_q;
  logic             lr_prev_q, lr_vld_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [IW-1:0]    idle_q;
  lock_e            state_q, state_d;
  logic [WIDTH-1:0] left_hold_q, right_hold_q;
  logic             left_flag_q, pair_go_q;
  logic [WIDTH-1:0] left_q, right_q;
  logic             valid_q, short_q;

  logic             rise, boundary, timeout, capture, cnt_room;
  logic [WIDTH-1:0] sh_ins, word;
  logic [CW-1:0]    cnt_ins;

  assign rise     = sclk_s & ~sclk_q;
  // lr_vld_q keeps the idle lrclk level seen at reset from faking a slot boundary
  assign boundary = rise && lr_vld_q && (lr_s != lr_prev_q);
  assign timeout  = !rise && (idle_q >= IW'(TIMEOUT - 1));

  // The boundary bit still belongs to the old slot, so fold it in before capture
  assign cnt_room = (bit_cnt_q < CW'(WIDTH));
  assign sh_ins   = cnt_room ? {shreg_q[WIDTH-2:0], sd_s} : shreg_q;
  assign cnt_ins  = cnt_room ? bit_cnt_q + 1'b1 : bit_cnt_q;
  assign word     = sh_ins << (WIDTH - 32'(cnt_ins));

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      LK_UNLOCKED: if (boundary) state_d = LK_ALIGNING;
      LK_ALIGNING: if (boundary) begin
        state_d = LK_LOCKED;
        capture = 1'b1;
      end
      LK_LOCKED:   if (boundary) capture = 1'b1;
      default:     state_d = LK_UNLOCKED;
    endcase
    if (timeout) state_d = LK_UNLOCKED;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LK_UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q       <= 1'b0;
      lr_prev_q    <= 1'b0;
      lr_vld_q     <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      idle_q       <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_flag_q  <= 1'b0;
      pair_go_q    <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      sclk_q    <= sclk_s;
      idle_q    <= rise ? '0 : ((idle_q < IW'(TIMEOUT)) ? idle_q + 1'b1 : idle_q);
      short_q   <= capture && (cnt_ins < CW'(WIDTH));
      pair_go_q <= 1'b0;
      if (rise) begin
        lr_vld_q  <= 1'b1;
        lr_prev_q <= lr_s;
        if (boundary) begin
          shreg_q   <= '0;
          bit_cnt_q <= '0;
        end else begin
          shreg_q   <= sh_ins;
          bit_cnt_q <= cnt_ins;
        end
      end
      if (capture) begin
        if (lr_prev_q == I2S_LEFT) begin
          left_hold_q <= word;
          left_flag_q <= 1'b1;
        end else begin
          right_hold_q <= word;
          if (left_flag_q && state_q == LK_LOCKED) begin
            pair_go_q   <= 1'b1;
            left_flag_q <= 1'b0;
          end
        end
      end
      if (state_d == LK_UNLOCKED) left_flag_q <= 1'b0;
    end
  end

  // Output stage: left and right move together so consumers never see a torn pair
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pair_go_q && (state_q == LK_LOCKED);
      if (pair_go_q && state_q == LK_LOCKED) begin
        left_q  <= left_hold_q;
        right_q <= right_hold_q;
      end
    end
  end

  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign sample_valid = valid_q;
  assign locked       = (state_q == LK_LOCKED);
  assign short_err    = short_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives Philips I2S frames and checks pairs, lock and errors.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int W  = 16;
  localparam int TO = 200;

  logic         clk = 1'b0;
  logic         reset_n, sclk, lrclk, sdata;
  logic [W-1:0] left_chan, right_chan;
  logic         sample_valid, locked, short_err;

  i2s_rx #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .left_chan(left_chan), .right_chan(right_chan), .sample_valid(sample_valid),
    .locked(locked), .short_err(short_err)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int n_vld = 0, n_short = 0;
  logic [W-1:0] cap_l[$], cap_r[$];
  logic pend = 1'b0;
  bit   rnd = 1'b0;

  always @(negedge clk) begin
    if (sample_valid) begin
      n_vld++;
      cap_l.push_back(left_chan);
      cap_r.push_back(right_chan);
    end
    if (short_err) n_short++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int hp();
    return rnd ? int'($urandom_range(25, 40)) : 40;
  endfunction

  // Transmitter view: lrclk and data change on the falling sclk edge, data lags lrclk by one bit
  task automatic tick(input logic lr, input logic b);
    int h;
    h = hp();
    sclk = 1'b0; lrclk = lr; sdata = pend; pend = b;
    #(h);
    sclk = 1'b1;
    #(h);
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) tick(lr, d[i]);
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
  endtask

  task automatic close_grp();
    tick(1'b0, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_pair(input string tag, input logic [W-1:0] el, input logic [W-1:0] er);
    chk({tag, "_avail"}, 32'(cap_l.size() > 0), 32'd1);
    if (cap_l.size() > 0) begin
      chk({tag, "_L"}, 32'(cap_l.pop_front()), 32'(el));
      chk({tag, "_R"}, 32'(cap_r.pop_front()), 32'(er));
    end
  endtask

  task automatic wait_unlock();
    repeat (TO + 40) @(negedge clk);
  endtask

  initial begin
    int v0, s0;
    logic [W-1:0] exp_l[$], exp_r[$];
    logic [W-1:0] rl, rr;

    reset_n = 1'b0; sclk = 1'b0; lrclk = 1'b1; sdata = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_left",  32'(left_chan), 32'd0);
    chk("rst_right", 32'(right_chan), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_short", 32'(short_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Post-reset: partial right slot discarded, lock only at the second lrclk edge
    v0 = n_vld; s0 = n_short;
    send_slot(1'b1, 32'h15, 5);
    send_slot(1'b0, 32'h8001, 16);
    repeat (4) @(negedge clk);
    chk("align_locked", 32'(locked), 32'd0);
    chk("align_novalid", 32'(n_vld - v0), 32'd0);
    send_slot(1'b1, 32'h7FFE, 16);
    chk("lock_after_2nd", 32'(locked), 32'd1);
    frame(32'h1234, 32'hFEDC, 16);
    close_grp();
    chk("g1_pulses", 32'(n_vld - v0), 32'd2);
    chk_pair("g1_p0", 16'h8001, 16'h7FFE);
    chk_pair("g1_p1", 16'h1234, 16'hFEDC);
    chk("g1_short", 32'(n_short - s0), 32'd0);

    // sclk stopped: lock held until idle counter expires, outputs frozen
    repeat (TO - 40) @(negedge clk);
    chk("to_before", 32'(locked), 32'd1);
    repeat (60) @(negedge clk);
    chk("to_after", 32'(locked), 32'd0);
    chk("to_hold_L", 32'(left_chan), 32'h1234);
    chk("to_hold_R", 32'(right_chan), 32'hFEDC);

    // 32-bit slots: keep the top 16 bits, no short error
    v0 = n_vld; s0 = n_short;
    send_slot(1'b1, 32'h0, 32);
    frame(32'hA5A5_1234, 32'h5A5A_8765, 32);
    close_grp();
    chk("g32_pulses", 32'(n_vld - v0), 32'd1);
    chk_pair("g32", 16'hA5A5, 16'h5A5A);
    chk("g32_short", 32'(n_short - s0), 32'd0);

    // 12-bit slots: zero-padded LSBs, one short error per captured slot
    wait_unlock();
    v0 = n_vld; s0 = n_short;
    send_slot(1'b1, 32'h0, 12);
    frame(32'hABC, 32'h123, 12);
    frame(32'hFFF, 32'h800, 12);
    close_grp();
    chk("g12_pulses", 32'(n_vld - v0), 32'd2);
    chk_pair("g12_p0", 16'hABC0, 16'h1230);
    chk_pair("g12_p1", 16'hFFF0, 16'h8000);
    chk("g12_short", 32'(n_short - s0), 32'd5);

    // Reset mid right slot: outputs clear asynchronously, relock from scratch
    wait_unlock();
    send_slot(1'b1, 32'h0, 16);
    send_slot(1'b0, 32'h5555, 16);
    for (int i = 15; i >= 8; i--) tick(1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mrst_left",  32'(left_chan), 32'd0);
    chk("mrst_right", 32'(right_chan), 32'd0);
    chk("mrst_locked", 32'(locked), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    v0 = n_vld;
    for (int i = 7; i >= 0; i--) tick(1'b1, 1'b1);
    send_slot(1'b0, 32'h3333, 16);
    chk("mrst_nopulse", 32'(n_vld - v0), 32'd0);
    send_slot(1'b1, 32'h4444, 16);
    close_grp();
    chk("mrst_pulses", 32'(n_vld - v0), 32'd1);
    chk_pair("mrst", 16'h3333, 16'h4444);

    // Random data with jittered sclk half-periods against the scoreboard
    wait_unlock();
    rnd = 1'b1;
    v0 = n_vld;
    send_slot(1'b1, 32'h0, 16);
    for (int f = 0; f < 20; f++) begin
      rl = W'($urandom);
      rr = W'($urandom);
      exp_l.push_back(rl);
      exp_r.push_back(rr);
      frame(32'(rl), 32'(rr), 16);
    end
    close_grp();
    chk("rnd_pulses", 32'(n_vld - v0), 32'd20);
    for (int f = 0; f < 20; f++) chk_pair($sformatf("rnd%0d", f), exp_l[f], exp_r[f]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
